// File: rtl/strategy_forgiving_grudger.sv
// rtl/strategy_forgiving_grudger.sv - iterated prisoner's-dilemma player with four strategy modes
//
// Purpose: answers one opponent move per round_start pulse with a registered
// decision. Modes: 0 grudger, 1 tit-for-tat, 2 tit-for-two-tats,
// 3 forgiving grudger (punish for `penalty` rounds, then forgive).
// Also exports opponent history and saturating statistics counters.
//
// Ports:
//   clk                 rising-edge clock
//   reset_n             asynchronous active-low reset
//   round_start         1-cycle pulse, play one round
//   opponent_last_move  opponent's previous move (1 defect, 0 cooperate)
//   mode                strategy mode, latched on the first round after reset
//   threshold           strikes needed to trigger (0 behaves as 1), latched
//   penalty             mode-3 punish length in rounds (0 = permanent), latched
//   decision            this round's move (1 defect, 0 cooperate)
//   decision_valid      1-cycle pulse when decision is updated
//   grudge_active       high while in PUNISH or GRUDGE
//   defect_count        saturating count of opponent defections
//   round_count         saturating count of rounds since reset
//   opp_history         opponent moves, bit0 most recent

module strategy_forgiving_grudger #(
  parameter int CNT_W  = 4,
  parameter int PEN_W  = 4,
  parameter int RND_W  = 8,
  parameter int HIST_D = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              round_start,
  input  logic              opponent_last_move,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  threshold,
  input  logic [PEN_W-1:0]  penalty,
  output logic              decision,
  output logic              decision_valid,
  output logic              grudge_active,
  output logic [CNT_W-1:0]  defect_count,
  output logic [RND_W-1:0]  round_count,
  output logic [HIST_D-1:0] opp_history
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COOP   = 2'd1,
    PUNISH = 2'd2,
    GRUDGE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_GRUDGER = 2'd0;
  localparam logic [1:0] MODE_TFT     = 2'd1;
  localparam logic [1:0] MODE_TF2T    = 2'd2;

  state_t           state;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_thr;
  logic [PEN_W-1:0] cfg_pen;
  logic [CNT_W-1:0] strikes;
  logic [PEN_W-1:0] pen_rem;

  logic             m;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] strikes_next;
  logic             trigger;

  assign m            = opponent_last_move;
  assign thr_eff      = (cfg_thr == '0) ? CNT_W'(1) : cfg_thr;
  assign strikes_next = (m && strikes != '1) ? strikes + CNT_W'(1) : strikes;
  assign trigger      = (strikes_next >= thr_eff);

  // State is itself a register, so grudge_active is a registered output.
  assign grudge_active = (state == PUNISH) || (state == GRUDGE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cfg_mode       <= '0;
      cfg_thr        <= '0;
      cfg_pen        <= '0;
      strikes        <= '0;
      pen_rem        <= '0;
      decision       <= 1'b0;
      decision_valid <= 1'b0;
      defect_count   <= '0;
      round_count    <= '0;
      opp_history    <= '0;
    end else begin
      decision_valid <= round_start;
      if (round_start) begin
        if (round_count != '1) round_count <= round_count + RND_W'(1);

        if (state == IDLE) begin
          // First round: the move input is meaningless, only configuration is captured.
          cfg_mode <= mode;
          cfg_thr  <= threshold;
          cfg_pen  <= penalty;
          decision <= 1'b0;
          state    <= COOP;
        end else begin
          opp_history <= {opp_history[HIST_D-2:0], m};
          if (m && defect_count != '1) defect_count <= defect_count + CNT_W'(1);

          if (cfg_mode == MODE_TFT) begin
            decision <= m;
          end else if (cfg_mode == MODE_TF2T) begin
            decision <= m & opp_history[0];
          end else begin
            case (state)
              COOP: begin
                strikes <= strikes_next;
                if (trigger) begin
                  decision <= 1'b1;
                  if (cfg_mode == MODE_GRUDGER || cfg_pen == '0) begin
                    state <= GRUDGE;
                  end else begin
                    // The triggering round is the first punish round.
                    state   <= PUNISH;
                    pen_rem <= cfg_pen - PEN_W'(1);
                  end
                end else begin
                  decision <= 1'b0;
                end
              end
              PUNISH: begin
                if (pen_rem != '0) begin
                  pen_rem  <= pen_rem - PEN_W'(1);
                  decision <= 1'b1;
                end else begin
                  // Forgiveness round: this round's move is not held against the opponent.
                  state    <= COOP;
                  strikes  <= '0;
                  decision <= 1'b0;
                end
              end
              default: begin
                decision <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

endmodule
